// File: rtl/kcc_pkg.sv
// Shared constants and controller state encoding for the kcc operand RAM.
package kcc_pkg;

  localparam int unsigned KCC_DATA_W = 16;
  localparam int unsigned KCC_ADDR_W = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } kcc_state_e;

endpackage

// File: rtl/kcc_dpram_core.sv
// Storage array: one write port shared with read port A, plus read port B with write forwarding.
module kcc_dpram_core #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              we,
  input  logic              ea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic              eb,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] doutb
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array write; no reset so the array maps onto block RAM.
  always_ff @(posedge clka) begin
    if (we) begin
      mem[addra] <= dina;
    end
  end

  // Port A read register, write-first.
  always_ff @(posedge clka) begin
    if (rsta) begin
      douta <= '0;
    end else if (ea) begin
      douta <= we ? dina : mem[addra];
    end
  end

  // Port B read register; a same-cycle write to the same address is forwarded.
  always_ff @(posedge clka) begin
    if (rsta) begin
      doutb <= '0;
    end else if (eb) begin
      doutb <= (we && (addrb == addra)) ? dina : mem[addrb];
    end
  end

endmodule

// File: rtl/kcc_dpram.sv
// Dual-port operand RAM with post-reset clear sequencer and optional output register.
module kcc_dpram
  import kcc_pkg::*;
#(
  parameter int unsigned DATA_W     = KCC_DATA_W,
  parameter int unsigned ADDR_W     = KCC_ADDR_W,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  input  logic              enb,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] doutb,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  kcc_state_e        state;
  kcc_state_e        state_next;
  logic [CNT_W-1:0]  clr_addr;

  logic              clearing;
  logic              user_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              rd_ena;
  logic              rd_enb;
  logic [DATA_W-1:0] core_douta;
  logic [DATA_W-1:0] core_doutb;

  // State register; busy tracks the next state so it is registered alongside it.
  always_ff @(posedge clka) begin
    if (rsta) begin
      state <= (INIT_CLEAR != 0) ? CLEAR : READY;
      busy  <= (INIT_CLEAR != 0);
    end else begin
      state <= state_next;
      busy  <= (state_next == CLEAR);
    end
  end

  // Next-state: leave CLEAR once the last word has been zeroed.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_addr == CNT_W'(DEPTH - 1)) state_next = READY;
      READY:   state_next = READY;
      default: state_next = READY;
    endcase
  end

  // Clear counter; the extra MSB keeps the terminal count distinct from address 0.
  always_ff @(posedge clka) begin
    if (rsta) begin
      clr_addr <= '0;
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + CNT_W'(1);
    end
  end

  // Write-source mux: clear sequencer owns the array while busy, user otherwise.
  always_comb begin
    clearing = (state == CLEAR) && !rsta;
    user_ok  = (state == READY) && !rsta;
    mem_we   = clearing || (user_ok && ena && wea);
    mem_addr = clearing ? clr_addr[ADDR_W-1:0] : addra;
    mem_din  = clearing ? '0 : dina;
    rd_ena   = user_ok && ena;
    rd_enb   = user_ok && enb;
  end

  kcc_dpram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clka  (clka),
    .rsta  (rsta),
    .we    (mem_we),
    .ea    (rd_ena),
    .addra (mem_addr),
    .dina  (mem_din),
    .eb    (rd_enb),
    .addrb (addrb),
    .douta (core_douta),
    .doutb (core_doutb)
  );

  if (OUT_REG != 0) begin : g_oreg
    logic              en_a_d;
    logic              en_b_d;
    logic [DATA_W-1:0] pipe_a;
    logic [DATA_W-1:0] pipe_b;

    // Output stage advances only behind a read that was actually enabled.
    always_ff @(posedge clka) begin
      if (rsta) begin
        en_a_d <= 1'b0;
        en_b_d <= 1'b0;
        pipe_a <= '0;
        pipe_b <= '0;
      end else begin
        en_a_d <= rd_ena;
        en_b_d <= rd_enb;
        if (en_a_d) pipe_a <= core_douta;
        if (en_b_d) pipe_b <= core_doutb;
      end
    end

    assign douta = pipe_a;
    assign doutb = pipe_b;
  end else begin : g_noreg
    assign douta = core_douta;
    assign doutb = core_doutb;
  end

endmodule

// File: tb/tb_kcc_dpram.sv
// Directed bench for kcc_dpram: default 16x256 instance and a 32x16 OUT_REG instance.
module tb_kcc_dpram;

  logic clk;
  int   checks;
  int   errors;
  int   n;

  logic        rsta0, ena0, wea0, enb0, busy0;
  logic [7:0]  addra0, addrb0;
  logic [15:0] dina0, douta0, doutb0;

  logic        rsta1, ena1, wea1, enb1, busy1;
  logic [3:0]  addra1, addrb1;
  logic [31:0] dina1, douta1, doutb1;

  kcc_dpram #(
    .DATA_W (16), .ADDR_W (8), .OUT_REG (0), .INIT_CLEAR (1)
  ) dut0 (
    .clka (clk), .rsta (rsta0), .ena (ena0), .wea (wea0), .addra (addra0),
    .dina (dina0), .douta (douta0), .enb (enb0), .addrb (addrb0),
    .doutb (doutb0), .busy (busy0)
  );

  kcc_dpram #(
    .DATA_W (32), .ADDR_W (4), .OUT_REG (1), .INIT_CLEAR (1)
  ) dut1 (
    .clka (clk), .rsta (rsta1), .ena (ena1), .wea (wea1), .addra (addra1),
    .dina (dina1), .douta (douta1), .enb (enb1), .addrb (addrb1),
    .doutb (doutb1), .busy (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rsta0 = 1'b1; ena0 = 1'b0; wea0 = 1'b0; enb0 = 1'b0;
    addra0 = '0; addrb0 = '0; dina0 = '0;
    rsta1 = 1'b1; ena1 = 1'b0; wea1 = 1'b0; enb1 = 1'b0;
    addra1 = '0; addrb1 = '0; dina1 = '0;

    // Reset values
    tick();
    check("rst_douta", 32'(douta0), 32'h0);
    check("rst_doutb", 32'(doutb0), 32'h0);
    check("rst_busy", 32'(busy0), 32'h1);

    // Reset clear: busy high for exactly 256 cycles
    rsta0 = 1'b0;
    n = 0;
    while (busy0 === 1'b1 && n < 1000) begin tick(); n++; end
    check("clear_len", 32'(n), 32'd256);

    // Cleared contents
    ena0 = 1'b1; addra0 = 8'h00; enb0 = 1'b1; addrb0 = 8'h7F;
    tick();
    check("clr_rd_00", 32'(douta0), 32'h0);
    check("clr_rd_7f", 32'(doutb0), 32'h0);
    addra0 = 8'hFF;
    tick();
    check("clr_rd_ff", 32'(douta0), 32'h0);

    // Write-first
    enb0 = 1'b0; wea0 = 1'b1; addra0 = 8'h12; dina0 = 16'hBEEF;
    tick();
    check("wf_douta", 32'(douta0), 32'hBEEF);
    wea0 = 1'b0; dina0 = 16'h0000;
    tick();
    check("wf_readback", 32'(douta0), 32'hBEEF);

    // Forwarding: seed 0x41, then same-cycle write/read of 0x40, then 0x41
    wea0 = 1'b1; addra0 = 8'h41; dina0 = 16'h7777;
    tick();
    addra0 = 8'h40; dina0 = 16'h1234; enb0 = 1'b1; addrb0 = 8'h40;
    tick();
    check("fwd_same", 32'(doutb0), 32'h1234);
    dina0 = 16'h5678; addrb0 = 8'h41;
    tick();
    check("fwd_other", 32'(doutb0), 32'h7777);

    // Hold: load 0xAAAA / 0x5555, read them, then disable both ports
    enb0 = 1'b0; addra0 = 8'h20; dina0 = 16'hAAAA;
    tick();
    addra0 = 8'h21; dina0 = 16'h5555;
    tick();
    wea0 = 1'b0; addra0 = 8'h20; enb0 = 1'b1; addrb0 = 8'h21;
    tick();
    check("hold_pre_a", 32'(douta0), 32'hAAAA);
    check("hold_pre_b", 32'(doutb0), 32'h5555);
    ena0 = 1'b0; enb0 = 1'b0; wea0 = 1'b1; dina0 = 16'h0F0F;
    addra0 = 8'h20; addrb0 = 8'h12;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_a", 32'(douta0), 32'hAAAA);
      check("hold_b", 32'(doutb0), 32'h5555);
    end
    // Disabled write must not have landed
    ena0 = 1'b1; wea0 = 1'b0; addra0 = 8'h20;
    tick();
    check("hold_nowrite", 32'(douta0), 32'hAAAA);

    // Busy lockout: write at clear cycle 10 is dropped
    ena0 = 1'b0; rsta0 = 1'b1;
    tick();
    rsta0 = 1'b0;
    n = 0;
    while (busy0 === 1'b1 && n < 1000) begin
      if (n == 10) begin
        ena0 = 1'b1; wea0 = 1'b1; enb0 = 1'b1; addra0 = 8'h03; dina0 = 16'hFFFF; addrb0 = 8'h03;
      end else begin
        ena0 = 1'b0; wea0 = 1'b0; enb0 = 1'b0;
      end
      tick();
      n++;
      if (n == 11) begin
        check("lock_douta", 32'(douta0), 32'h0);
        check("lock_doutb", 32'(doutb0), 32'h0);
      end
    end
    check("lock_clear_len", 32'(n), 32'd256);
    ena0 = 1'b1; wea0 = 1'b0; addra0 = 8'h03; enb0 = 1'b1; addrb0 = 8'h12;
    tick();
    check("lock_dropped", 32'(douta0), 32'h0);
    check("lock_recleared", 32'(doutb0), 32'h0);

    // Mid-clear reset at clear cycle 100 restarts the full sequence
    ena0 = 1'b1; wea0 = 1'b1; addra0 = 8'hF0; dina0 = 16'hC0DE; enb0 = 1'b0;
    tick();
    ena0 = 1'b0; wea0 = 1'b0; rsta0 = 1'b1;
    tick();
    rsta0 = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check("mid_busy", 32'(busy0), 32'h1);
    rsta0 = 1'b1;
    tick();
    rsta0 = 1'b0;
    n = 0;
    while (busy0 === 1'b1 && n < 1000) begin tick(); n++; end
    check("mid_clear_len", 32'(n), 32'd256);
    ena0 = 1'b1; addra0 = 8'hF0;
    tick();
    check("mid_cleared", 32'(douta0), 32'h0);
    ena0 = 1'b0;

    // OUT_REG=1, 32x16 instance
    check("r1_busy", 32'(busy1), 32'h1);
    check("r1_douta", douta1, 32'h0);
    rsta1 = 1'b0;
    n = 0;
    while (busy1 === 1'b1 && n < 1000) begin tick(); n++; end
    check("r1_clear_len", 32'(n), 32'd16);

    ena1 = 1'b1; wea1 = 1'b1; addra1 = 4'hF; dina1 = 32'hDEADBEEF;
    tick();
    ena1 = 1'b0; wea1 = 1'b0;
    check("r1_wr_lat1", douta1, 32'h0);
    tick();
    check("r1_wr_lat2", douta1, 32'hDEADBEEF);

    ena1 = 1'b1; addra1 = 4'h0; enb1 = 1'b1; addrb1 = 4'hF;
    tick();
    ena1 = 1'b0; enb1 = 1'b0;
    check("r1_rd_lat1_a", douta1, 32'hDEADBEEF);
    check("r1_rd_lat1_b", doutb1, 32'h0);
    tick();
    check("r1_rd_lat2_a", douta1, 32'h0);
    check("r1_rd_lat2_b", doutb1, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r1_hold_a", douta1, 32'h0);
      check("r1_hold_b", doutb1, 32'hDEADBEEF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
